// File: rtl/uart_tx_if.sv
// CPU-side write port and serial/status outputs of the UART transmitter.
interface uart_tx_if;
  logic       WR;
  logic [7:0] Din;
  logic       TxD;
  logic       TxRDY;
  logic       Busy;
  logic       Idle;
  logic       Start;
  logic       Shift;
  logic       Parity;
  logic       Stop;

  modport master (
    output WR, Din,
    input  TxD, TxRDY, Busy, Idle, Start, Shift, Parity, Stop
  );

  modport slave (
    input  WR, Din,
    output TxD, TxRDY, Busy, Idle, Start, Shift, Parity, Stop
  );
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: one-entry holding register (THR) feeding a shift
// register (TSR); frames are start, 8 data bits LSB first, parity, stop.
// Each non-idle state lasts CLKS_PER_BIT clocks.
module uart_tx_unit #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic     Clock,
  input  logic     Reset,
  uart_tx_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state, state_n;
  logic [7:0]  thr, thr_n;
  logic        thr_full, thr_full_n;
  logic [7:0]  tsr, tsr_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [15:0] baud, baud_n;
  logic        par, par_n;
  logic        load;
  logic        wr_ok;
  logic        baud_last;
  logic        txd_n;

  logic txd_q, txrdy_q, busy_q;
  logic idle_q, start_q, shift_q, parity_q, stop_q;

  assign baud_last = (baud == BAUD_MAX);
  // THR is still full during a transfer cycle, so a coincident write is dropped.
  assign wr_ok     = bus.WR && !thr_full;

  // Next-state selection; load marks a THR->TSR transfer on this edge.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (thr_full) begin
          state_n = S_START;
          load    = 1'b1;
        end
      end
      S_START:  if (baud_last) state_n = S_SHIFT;
      S_SHIFT:  if (baud_last && bitcnt == 3'd7) state_n = S_PARITY;
      S_PARITY: if (baud_last) state_n = S_STOP;
      S_STOP: begin
        if (baud_last) begin
          if (thr_full) begin
            state_n = S_START;
            load    = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath and counter updates that follow from the chosen transition.
  always_comb begin
    thr_n      = wr_ok ? bus.Din : thr;
    thr_full_n = wr_ok ? 1'b1 : (load ? 1'b0 : thr_full);

    if (load)
      tsr_n = thr;
    else if (state == S_SHIFT && baud_last)
      tsr_n = {1'b0, tsr[7:1]};
    else
      tsr_n = tsr;

    par_n = load ? (^thr ^ PARITY_ODD) : par;

    if (state == S_START && state_n == S_SHIFT)
      bitcnt_n = 3'd0;
    else if (state == S_SHIFT && baud_last)
      bitcnt_n = bitcnt + 3'd1;
    else
      bitcnt_n = bitcnt;

    // Baud counter clears on every state entry and wraps at each bit boundary.
    if (state_n != state || state == S_IDLE || baud_last)
      baud_n = 16'd0;
    else
      baud_n = baud + 16'd1;

    case (state_n)
      S_START:  txd_n = 1'b0;
      S_SHIFT:  txd_n = tsr_n[0];
      S_PARITY: txd_n = par_n;
      default:  txd_n = 1'b1;
    endcase
  end

  // Register state, storage and the outputs derived from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      thr      <= 8'h00;
      thr_full <= 1'b0;
      tsr      <= 8'h00;
      bitcnt   <= 3'd0;
      baud     <= 16'd0;
      par      <= 1'b0;
      txd_q    <= 1'b1;
      txrdy_q  <= 1'b1;
      busy_q   <= 1'b0;
      idle_q   <= 1'b1;
      start_q  <= 1'b0;
      shift_q  <= 1'b0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state    <= state_n;
      thr      <= thr_n;
      thr_full <= thr_full_n;
      tsr      <= tsr_n;
      bitcnt   <= bitcnt_n;
      baud     <= baud_n;
      par      <= par_n;
      txd_q    <= txd_n;
      txrdy_q  <= !thr_full_n;
      busy_q   <= (state_n != S_IDLE);
      idle_q   <= (state_n == S_IDLE);
      start_q  <= (state_n == S_START);
      shift_q  <= (state_n == S_SHIFT);
      parity_q <= (state_n == S_PARITY);
      stop_q   <= (state_n == S_STOP);
    end
  end

  assign bus.TxD    = txd_q;
  assign bus.TxRDY  = txrdy_q;
  assign bus.Busy   = busy_q;
  assign bus.Idle   = idle_q;
  assign bus.Start  = start_q;
  assign bus.Shift  = shift_q;
  assign bus.Parity = parity_q;
  assign bus.Stop   = stop_q;

endmodule
